// File: rtl/sram_2p_masked_array.sv
// Behavioural 1W/1R SRAM with per-lane write masks, 1- or 2-cycle read latency,
// same-address bypass selection and an optional post-reset zeroing sweep.
module sram_2p_masked_array #(
    parameter int DATA_WIDTH   = 128,
    parameter int DEPTH        = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int LANE_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int BYPASS       = 1,
    parameter int INIT_ZERO    = 1
) (
    input  logic                               CLK,
    input  logic                               RSTB,
    input  logic                               WEB,
    input  logic [ADDR_WIDTH-1:0]              AA,
    input  logic [DATA_WIDTH-1:0]              D,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   BWEB,
    input  logic                               REB,
    input  logic [ADDR_WIDTH-1:0]              AB,
    output logic [DATA_WIDTH-1:0]              Q,
    output logic                               QV,
    output logic                               RDY
);

    localparam int NLANES = DATA_WIDTH / LANE_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam logic [0:0] ST_RESET = (INIT_ZERO != 0) ? ST_INIT : ST_READY;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rdy_q;
    logic [DATA_WIDTH-1:0] q_q;
    logic                  qv_q;

    logic                  wrInRange, rdInRange;
    logic                  wrFire, rdFire, initWr;
    logic [DATA_WIDTH-1:0] wrOld, wrMerged, rdOld, rdWord;
    logic [DATA_WIDTH-1:0] outData;
    logic                  outValid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_READY;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= (state_d == ST_READY);
        end
    end

    // Accesses are only honoured once RDY has been visible for a full cycle.
    assign initWr    = (state_q == ST_INIT);
    assign wrInRange = ({1'b0, AA} < DEPTH_EXT);
    assign rdInRange = ({1'b0, AB} < DEPTH_EXT);
    assign wrFire    = rdy_q && !WEB && wrInRange;
    assign rdFire    = rdy_q && !REB;

    always_comb begin
        wrOld    = wrInRange ? mem[AA] : '0;
        wrMerged = wrOld;
        for (int i = 0; i < NLANES; i++) begin
            if (!BWEB[i]) begin
                wrMerged[i*LANE_WIDTH +: LANE_WIDTH] = D[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    always_comb begin
        rdOld  = rdInRange ? mem[AB] : '0;
        rdWord = rdOld;
        if (!rdInRange) begin
            rdWord = '0;
        end else if ((BYPASS != 0) && wrFire && (AA == AB)) begin
            rdWord = wrMerged;
        end
    end

    always_ff @(posedge CLK) begin
        if (initWr) begin
            mem[cnt_q] <= '0;
        end else if (wrFire) begin
            mem[AA] <= wrMerged;
        end
    end

    // Two-cycle builds capture the word at the request edge so later writes cannot alter it.
    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] pipeData_q;
        logic                  pipeValid_q;

        always_ff @(posedge CLK or negedge RSTB) begin
            if (!RSTB) begin
                pipeData_q  <= '0;
                pipeValid_q <= 1'b0;
            end else begin
                pipeValid_q <= rdFire;
                if (rdFire) begin
                    pipeData_q <= rdWord;
                end
            end
        end

        assign outData  = pipeData_q;
        assign outValid = pipeValid_q;
    end else begin : g_lat1
        assign outData  = rdWord;
        assign outValid = rdFire;
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            q_q  <= '0;
            qv_q <= 1'b0;
        end else begin
            qv_q <= outValid;
            if (outValid) begin
                q_q <= outData;
            end
        end
    end

    assign Q   = q_q;
    assign QV  = qv_q;
    assign RDY = rdy_q;

endmodule

// File: doc/sram_2p_masked_array.md
Name: sram_2p_masked_array

Overview:
- Parametrised behavioural model of a two-port (1W/1R) SRAM macro, the next generation of the fixed 16x128 register-file models.
- Used in simulation and FPGA builds in place of the foundry macros.
- Adds per-lane write masks, configurable read latency and same-address write-to-read bypass.
- Adds a deterministic hold on idle reads, an output-valid flag, and an optional post-reset zero-initialisation sweep with a ready indication.

Parameters:
- DATA_WIDTH, 128, bits per word.
- DEPTH, 16, number of words; need not be a power of two.
- ADDR_WIDTH, 4, address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- LANE_WIDTH, 8, bits per write-mask lane; DATA_WIDTH must be a multiple of it. NLANES = DATA_WIDTH/LANE_WIDTH.
- READ_LATENCY, 1, read latency; legal values are 1 and 2.
- BYPASS, 1, same-address collision policy: 1 = read returns new data, 0 = read returns old data.
- INIT_ZERO, 1, 1 = zero all words after reset before asserting RDY.

Ports:
- CLK  input  1  single clock for both ports (replaces CLKW/CLKR).
- RSTB  input  1  asynchronous, active-low reset.
- WEB  input  1  write enable, active-low.
- AA  input  ADDR_WIDTH  write address.
- D  input  DATA_WIDTH  write data.
- BWEB  input  NLANES  per-lane write enable, active-low; lane i = D[i*LANE_WIDTH +: LANE_WIDTH].
- REB  input  1  read enable, active-low.
- AB  input  ADDR_WIDTH  read address.
- Q  output  DATA_WIDTH  read data.
- QV  output  1  Q updated by a read this cycle.
- RDY  output  1  array accepting accesses.

Behaviour:
- Reset (RSTB=0, asynchronous):
  - Q=0, QV=0, RDY=0; all read-pipeline registers and valids cleared.
  - FSM goes to INIT if INIT_ZERO=1, else READY.
  - Array contents are NOT reset.
- FSM states:
  - INIT: counter starts at 0. Each edge writes all-zero to ram[cnt], then cnt++. After writing DEPTH-1, go to READY. RDY stays 0 throughout; WEB/REB/BWEB are ignored. INIT lasts DEPTH cycles after reset release.
  - READY: RDY=1, registered. The first accepted access is on the edge after RDY is seen high. This applies from the first edge after reset release when INIT_ZERO=0.
  - Reset asserted during INIT aborts the sweep; after release the sweep restarts at address 0.
- Write (READY, WEB=0 at posedge):
  - For each lane with BWEB[i]=0, ram[AA] lane i <= D lane i; other lanes are unchanged.
  - BWEB all ones means no change.
  - AA >= DEPTH: write dropped.
- Read (READY, REB=0 at posedge t):
  - Word sampled at edge t.
  - READ_LATENCY=1: Q/QV update at edge t.
  - READ_LATENCY=2: Q/QV update at edge t+1. Data is captured at edge t, so later writes do not alter an in-flight read.
  - Back-to-back reads are fully pipelined: one result per cycle.
- Idle read: a cycle with no read completing gives QV=0 and Q holds its last value. No random data is ever produced.
- AB >= DEPTH: Q=0 with QV=1.
- Collision (read and write at the same edge, AB==AA, both in range):
  - BYPASS=1: Q = merged word; written lanes take D, unwritten lanes take old contents.
  - BYPASS=0: Q = old contents.
  - Different addresses: no interaction.
- Reset asserted with reads in flight: the reads are discarded and never produce QV.
- No X propagation from uninitialised words when INIT_ZERO=1.

Test Plan:
- INIT sweep, INIT_ZERO=1, DEPTH=16:
  - Release reset -> RDY rises exactly 16 cycles later.
  - Reads of addresses 0..15 then return 0 with QV=1, one per cycle.
  - Writes issued during INIT have no effect.
- Masked write:
  - Write 0xFF..FF to addr 3, then write D=0 with BWEB=0xFFFE to addr 3.
  - Read addr 3 -> lane 0 = 0x00, all other lanes 0xFF.
- Latency and pipelining, READ_LATENCY=2:
  - Write 0xA5 pattern to addr 5 and 0x5A pattern to addr 6.
  - Read 5 then 6 back-to-back -> Q=pattern5 at edge t+1 and pattern6 at edge t+2, QV high for both.
  - Idle cycle after -> QV=0 and Q still pattern6.
- Collision:
  - addr 7 holds 0x11..11. Same edge: write 0x22..22 with BWEB=0xFF00, read addr 7.
  - BYPASS=1 -> low 8 lanes 0x22, upper 8 lanes 0x11.
  - BYPASS=0 -> all lanes 0x11.
  - Next-cycle read returns the merged word in both builds.
- Out of range, DEPTH=12:
  - Write to addr 13 -> no array word changes.
  - Read addr 14 -> Q=0, QV=1.
- Reset mid-operation:
  - Assert RSTB=0 at INIT count 9 and again with two reads in flight (READ_LATENCY=2).
  - -> Q=0 and QV=0 immediately (asynchronous); no stale QV after release.
  - INIT restarts and RDY rises DEPTH cycles after release.
